// File: rtl/leg_vector_servo_drive.sv
// Leg-vector consumer: squares and sums x/y/z over three cycles with one multiplier,
// maps the squared length to a servo pulse width and drives a fixed-period PWM.
// Optional build macro SERVO_SLEW_LIMIT_EN limits the per-period change of pw_active.
module leg_vector_servo_drive #(
    parameter int unsigned     PERIOD_CYC  = 2000000,
    parameter int unsigned     PW_MIN      = 100000,
    parameter int unsigned     PW_MAX      = 200000,
    parameter longint unsigned LSQ_MIN     = 0,
    parameter int unsigned     SCALE_SHIFT = 8,
    parameter int unsigned     SLEW_STEP   = 1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [50:0] leg_vector,
    input  logic        vec_valid,
    output logic        vec_ready,
    output logic [35:0] len_sq,
    output logic        calc_done,
    output logic [20:0] pw_pending,
    output logic [20:0] pw_active,
    output logic        pwm_out
);

    localparam int unsigned   CW       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYC - 1);
    localparam logic [20:0]   PW_RST   = 21'((PW_MIN + PW_MAX) / 2);

    typedef enum logic [2:0] {IDLE, SQ_X, SQ_Y, SQ_Z, MAP} state_e;

    state_e             state_q, state_d;
    logic signed [16:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [35:0]        acc_q, acc_d;
    logic [35:0]        len_sq_q, len_sq_d;
    logic [20:0]        pw_pending_q, pw_pending_d;
    logic [20:0]        pw_active_q, pw_active_d;
    logic               calc_done_q, calc_done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pwm_q, pwm_d;
    logic               wrap;

    logic signed [16:0] op;
    logic signed [33:0] sq;
    logic [36:0]        diff, t;
    logic [20:0]        pw_map;

    // One shared squarer; the FSM state selects which component feeds it.
    always_comb begin
        op = x_q;
        case (state_q)
            SQ_Y:    op = y_q;
            SQ_Z:    op = z_q;
            default: op = x_q;
        endcase
        sq = op * op;
    end

    // Linear map at 37 bits so the shifted length plus PW_MIN cannot wrap before clamping.
    always_comb begin
        diff = 37'(acc_q) - 37'(LSQ_MIN);
        t    = 37'(PW_MIN) + (diff >> SCALE_SHIFT);
        if (acc_q <= 36'(LSQ_MIN)) begin
            pw_map = 21'(PW_MIN);
        end else if (t > 37'(PW_MAX)) begin
            pw_map = 21'(PW_MAX);
        end else begin
            pw_map = t[20:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        acc_d        = acc_q;
        len_sq_d     = len_sq_q;
        pw_pending_d = pw_pending_q;
        calc_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (vec_valid) begin
                    x_d     = leg_vector[16:0];
                    y_d     = leg_vector[33:17];
                    z_d     = leg_vector[50:34];
                    acc_d   = '0;
                    state_d = SQ_X;
                end
            end
            SQ_X: begin
                acc_d   = acc_q + {2'b00, sq};
                state_d = SQ_Y;
            end
            SQ_Y: begin
                acc_d   = acc_q + {2'b00, sq};
                state_d = SQ_Z;
            end
            SQ_Z: begin
                acc_d   = acc_q + {2'b00, sq};
                state_d = MAP;
            end
            MAP: begin
                len_sq_d     = acc_q;
                pw_pending_d = pw_map;
                calc_done_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wrap        = (cnt_q == CNT_LAST);
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        pwm_d       = (32'(cnt_q) < 32'(pw_active_q));
        pw_active_d = pw_active_q;
        if (wrap) begin
`ifdef SERVO_SLEW_LIMIT_EN
            if (pw_pending_q >= pw_active_q) begin
                pw_active_d = (pw_pending_q - pw_active_q <= 21'(SLEW_STEP)) ?
                              pw_pending_q : pw_active_q + 21'(SLEW_STEP);
            end else begin
                pw_active_d = (pw_active_q - pw_pending_q <= 21'(SLEW_STEP)) ?
                              pw_pending_q : pw_active_q - 21'(SLEW_STEP);
            end
`else
            pw_active_d = pw_pending_q;
`endif
        end
    end

`ifndef SERVO_SLEW_LIMIT_EN
    // Without slew limiting the step size has no effect.
    logic unused_slew;
    assign unused_slew = ^SLEW_STEP;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            acc_q        <= '0;
            len_sq_q     <= '0;
            pw_pending_q <= PW_RST;
            pw_active_q  <= PW_RST;
            calc_done_q  <= 1'b0;
            cnt_q        <= '0;
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            acc_q        <= acc_d;
            len_sq_q     <= len_sq_d;
            pw_pending_q <= pw_pending_d;
            pw_active_q  <= pw_active_d;
            calc_done_q  <= calc_done_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
        end
    end

    assign vec_ready  = (state_q == IDLE);
    assign len_sq     = len_sq_q;
    assign calc_done  = calc_done_q;
    assign pw_pending = pw_pending_q;
    assign pw_active  = pw_active_q;
    assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_leg_vector_servo_drive.sv
// Self-checking bench for leg_vector_servo_drive: scoreboard of expected len_sq/pw_pending,
// latency, back-to-back handshake, PWM widths and wrap/update coincidence.
module tb_leg_vector_servo_drive;

    localparam int unsigned PERIOD = 1000;

    logic        clock;
    logic        reset_n;
    logic [50:0] leg_vector;
    logic        vec_valid;
    logic        vec_ready;
    logic [35:0] len_sq;
    logic        calc_done;
    logic [20:0] pw_pending;
    logic [20:0] pw_active;
    logic        pwm_out;

    typedef struct packed {
        logic [35:0] len;
        logic [20:0] pw;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    leg_vector_servo_drive #(
        .PERIOD_CYC (PERIOD),
        .PW_MIN     (100),
        .PW_MAX     (200),
        .LSQ_MIN    (0),
        .SCALE_SHIFT(4),
        .SLEW_STEP  (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .leg_vector(leg_vector),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .len_sq    (len_sq),
        .calc_done (calc_done),
        .pw_pending(pw_pending),
        .pw_active (pw_active),
        .pwm_out   (pwm_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [50:0] pack(input int x, input int y, input int z);
        logic [16:0] px, py, pz;
        px = 17'(x);
        py = 17'(y);
        pz = 17'(z);
        return {pz, py, px};
    endfunction

    function automatic logic [35:0] model_len(input int x, input int y, input int z);
        longint lx, ly, lz;
        lx = x;
        ly = y;
        lz = z;
        return 36'(lx * lx + ly * ly + lz * lz);
    endfunction

    function automatic logic [20:0] model_pw(input logic [35:0] l);
        longint tt;
        if (l == 36'd0) return 21'd100;
        tt = 100 + (longint'(l) >> 4);
        if (tt > 200) tt = 200;
        return 21'(tt);
    endfunction

    // Returns one cycle after the edge where pwm_out rises (start of a period).
    task automatic wait_rise(output bit ok);
        int c;
        ok = 1'b0;
        c  = 0;
        while (pwm_out !== 1'b0 && c < 2 * PERIOD) begin
            @(posedge clock); #1; c++;
        end
        c = 0;
        while (pwm_out !== 1'b1 && c < 2 * PERIOD) begin
            @(posedge clock); #1; c++;
        end
        ok = (pwm_out === 1'b1);
    endtask

    task automatic measure_period(output int w);
        bit ok;
        w = -1;
        wait_rise(ok);
        if (ok) begin
            w = 1;
            @(posedge clock); #1;
            while (pwm_out === 1'b1 && w <= PERIOD) begin
                w++;
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic send_and_check(input int x, input int y, input int z, input string nm);
        int   c;
        exp_t e;
        c = 0;
        while (vec_ready !== 1'b1 && c < 20) begin
            @(posedge clock); #1; c++;
        end
        leg_vector = pack(x, y, z);
        vec_valid  = 1'b1;
        sb.push_back('{len: model_len(x, y, z), pw: model_pw(model_len(x, y, z))});
        @(posedge clock); #1;
        vec_valid = 1'b0;
        c = 0;
        while (c < 10) begin
            @(posedge clock); #1; c++;
            if (calc_done === 1'b1) break;
        end
        n_assert++;
        if (calc_done !== 1'b1 || c != 4) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (calc_done=%b) expected 4", nm, c, calc_done);
        end
        e = sb.pop_front();
        n_assert++;
        if (len_sq !== e.len) begin
            n_fail++;
            $display("FAIL %s len_sq: got %0d expected %0d", nm, len_sq, e.len);
        end
        n_assert++;
        if (pw_pending !== e.pw) begin
            n_fail++;
            $display("FAIL %s pw_pending: got %0d expected %0d", nm, pw_pending, e.pw);
        end
        @(posedge clock); #1;
        n_assert++;
        if (calc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s calc_done pulse: got %b expected 0", nm, calc_done);
        end
    endtask

    task automatic test_reset;
        int w;
        repeat (60) @(posedge clock);
        #1;
        n_assert++;
        if (pwm_out !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_pwm: got %b expected 1", pwm_out);
        end
        #3 reset_n = 1'b0;
        #1;
        n_assert++;
        if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        n_assert++;
        if (vec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", vec_ready); end
        n_assert++;
        if (pw_active !== 21'd150) begin n_fail++; $display("FAIL reset_pw_active: got %0d expected 150", pw_active); end
        n_assert++;
        if (pw_pending !== 21'd150) begin n_fail++; $display("FAIL reset_pw_pending: got %0d expected 150", pw_pending); end
        n_assert++;
        if (len_sq !== 36'd0) begin n_fail++; $display("FAIL reset_len_sq: got %0d expected 0", len_sq); end
        n_assert++;
        if (calc_done !== 1'b0) begin n_fail++; $display("FAIL reset_calc_done: got %b expected 0", calc_done); end
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 2; i++) begin
            measure_period(w);
            n_assert++;
            if (w != 150) begin n_fail++; $display("FAIL reset_width%0d: got %0d expected 150", i, w); end
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        leg_vector = pack(3, 4, 12);
        vec_valid  = 1'b1;
        @(posedge clock); #1;
        vec_valid = 1'b0;
        @(posedge clock); #1;
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (calc_done === 1'b1) seen = 1'b1;
        end
        n_assert++;
        if (seen) begin n_fail++; $display("FAIL abort_calc_done: got 1 expected 0"); end
        n_assert++;
        if (len_sq !== 36'd0) begin n_fail++; $display("FAIL abort_len_sq: got %0d expected 0", len_sq); end
    endtask

    task automatic test_map;
        int w;
        send_and_check(3, 4, 12, "vec_3_4_12");
`ifndef SERVO_SLEW_LIMIT_EN
        measure_period(w);
        n_assert++;
        if (w != 110) begin n_fail++; $display("FAIL width_110: got %0d expected 110", w); end
`endif
        send_and_check(-65536, 0, 0, "vec_fullscale");
        send_and_check(10, 20, -30, "vec_mid");
        send_and_check(65535, -65535, 65535, "vec_max_pos");
        send_and_check(0, 0, 0, "vec_zero");
`ifndef SERVO_SLEW_LIMIT_EN
        measure_period(w);
        n_assert++;
        if (w != 100) begin n_fail++; $display("FAIL width_100: got %0d expected 100", w); end
`else
        w = 0;
`endif
    endtask

    task automatic test_back_to_back;
        int   acc_edge[2];
        int   acc, dn;
        bit   r;
        exp_t e;
        acc = 0;
        dn  = 0;
        leg_vector = pack(1, 2, 2);
        vec_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            r = vec_ready && vec_valid;
            @(posedge clock); #1;
            if (r) begin
                if (acc < 2) acc_edge[acc] = c;
                if (acc == 0) begin
                    sb.push_back('{len: model_len(1, 2, 2), pw: model_pw(model_len(1, 2, 2))});
                    leg_vector = pack(-7, 8, 0);
                end else begin
                    sb.push_back('{len: model_len(-7, 8, 0), pw: model_pw(model_len(-7, 8, 0))});
                    vec_valid = 1'b0;
                end
                acc++;
            end
            if (calc_done === 1'b1) begin
                dn++;
                n_assert++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_done: got calc_done with empty scoreboard expected none");
                end else begin
                    e = sb.pop_front();
                    if (len_sq !== e.len || pw_pending !== e.pw) begin
                        n_fail++;
                        $display("FAIL b2b_result%0d: got len=%0d pw=%0d expected len=%0d pw=%0d",
                                 dn, len_sq, pw_pending, e.len, e.pw);
                    end
                end
            end
        end
        vec_valid = 1'b0;
        n_assert++;
        if (acc != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", acc); end
        n_assert++;
        if (acc == 2 && acc_edge[1] - acc_edge[0] != 5) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d expected 5", acc_edge[1] - acc_edge[0]);
        end
        n_assert++;
        if (dn != 2) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 2", dn); end
        n_assert++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    // pw_pending is 107 here; the update to 110 lands on the wrap edge itself.
    task automatic test_wrap_coincide;
        bit   ok;
        int   w;
        exp_t e;
        wait_rise(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL wrap_sync: got no pwm rise expected one"); end
        repeat (PERIOD - 6) @(posedge clock);
        #1;
        leg_vector = pack(3, 4, 12);
        vec_valid  = 1'b1;
        sb.push_back('{len: model_len(3, 4, 12), pw: model_pw(model_len(3, 4, 12))});
        @(posedge clock); #1;
        vec_valid = 1'b0;
        n_assert++;
        if (vec_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_accept: got ready=%b expected 0", vec_ready); end
        repeat (4) @(posedge clock);
        #1;
        e = sb.pop_front();
        n_assert++;
        if (calc_done !== 1'b1 || pw_pending !== e.pw) begin
            n_fail++;
            $display("FAIL wrap_done: got done=%b pw=%0d expected done=1 pw=%0d", calc_done, pw_pending, e.pw);
        end
`ifndef SERVO_SLEW_LIMIT_EN
        n_assert++;
        if (pw_active !== 21'd107) begin n_fail++; $display("FAIL wrap_active: got %0d expected 107", pw_active); end
        measure_period(w);
        n_assert++;
        if (w != 107) begin n_fail++; $display("FAIL wrap_old_width: got %0d expected 107", w); end
        measure_period(w);
        n_assert++;
        if (w != 110) begin n_fail++; $display("FAIL wrap_new_width: got %0d expected 110", w); end
`else
        w = 0;
`endif
    endtask

`ifdef SERVO_SLEW_LIMIT_EN
    task automatic test_slew;
        int w;
        int expw;
        @(posedge clock); #1;
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        send_and_check(-65536, 0, 0, "slew_target");
        expw = 150;
        for (int i = 0; i < 12; i++) begin
            if (expw < 200) expw += 5;
            measure_period(w);
            n_assert++;
            if (w != expw) begin n_fail++; $display("FAIL slew_period%0d: got %0d expected %0d", i, w, expw); end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        vec_valid  = 1'b0;
        leg_vector = '0;
        #23 reset_n = 1'b1;
        @(posedge clock); #1;
        test_reset;
        test_reset_abort;
        test_map;
        test_back_to_back;
        test_wrap_coincide;
`ifdef SERVO_SLEW_LIMIT_EN
        test_slew;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
